// File: rtl/dds_pkg.sv
// Shared definitions for the DDS output stage: sample width, serializer
// state encoding and a constant-foldable ceil(log2) helper.
package dds_pkg;

  localparam int SAMPLE_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } dac_state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dds_dac_serializer_if.sv
// Sample input stream, overflow control and DAC serial bus of the DDS output stage.
// The slave side is the serializer; the master side is whoever feeds it and watches the DAC pins.
interface dds_dac_serializer_if;
  import dds_pkg::*;

  logic [SAMPLE_W-1:0] sin_amp;
  logic                trans_in;
  logic                ovf_clr;
  logic                dac_sclk;
  logic                dac_sdata;
  logic                dac_cs_n;
  logic                busy;
  logic                ovf;

  modport master (
    output sin_amp, trans_in, ovf_clr,
    input  dac_sclk, dac_sdata, dac_cs_n, busy, ovf
  );

  modport slave (
    input  sin_amp, trans_in, ovf_clr,
    output dac_sclk, dac_sdata, dac_cs_n, busy, ovf
  );

endinterface

// File: rtl/dds_sample_fifo.sv
// Small synchronous FIFO with show-ahead output; pointers carry one extra
// wrap bit so full and empty are distinguishable. Storage has no reset.
module dds_sample_fifo
  import dds_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A pop in the same cycle frees the slot, so a push on a full FIFO still lands.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/dds_dac_serializer.sv
// Buffers DDS samples and shifts them MSB-first to an SPI-style DAC, flagging dropped samples.
// Optional: define DDS_DAC_OFFSET_BIN_EN to send offset binary (bit 15 inverted) instead of two's complement.
module dds_dac_serializer
  import dds_pkg::*;
#(
  parameter int DIV   = 2,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  dds_dac_serializer_if.slave  bus
);

  localparam int            DW       = clog2(DIV) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  dac_state_t          state;
  logic [DW-1:0]       div_cnt;
  logic                phase;
  logic [3:0]          bit_cnt;
  logic [SAMPLE_W-1:0] shreg;
  logic [SAMPLE_W-1:0] fifo_dout;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic                half_done;

  assign pop       = (state == IDLE) && !fifo_empty;
  assign half_done = (div_cnt == DIV_LAST);

  dds_sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.trans_in),
    .pop   (pop),
    .din   (bus.sin_amp),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  function automatic logic [SAMPLE_W-1:0] load_word(input logic [SAMPLE_W-1:0] s);
`ifdef DDS_DAC_OFFSET_BIN_EN
    return {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]};
`else
    return s;
`endif
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      div_cnt       <= '0;
      phase         <= 1'b0;
      bit_cnt       <= '0;
      bus.dac_sclk  <= 1'b0;
      bus.dac_sdata <= 1'b0;
      bus.dac_cs_n  <= 1'b1;
      bus.busy      <= 1'b0;
    end else begin
      // Pins register the state of the cycle just ended, so they trail the FSM by one clock.
      bus.dac_cs_n  <= (state != SHIFT);
      bus.dac_sclk  <= (state == SHIFT) && phase;
      bus.dac_sdata <= (state == SHIFT) && shreg[SAMPLE_W-1];
      bus.busy      <= (state != IDLE);
      case (state)
        IDLE: begin
          div_cnt <= '0;
          phase   <= 1'b0;
          if (!fifo_empty) begin
            state   <= SHIFT;
            bit_cnt <= 4'd15;
          end
        end
        SHIFT: begin
          if (half_done) begin
            div_cnt <= '0;
            phase   <= ~phase;
            if (phase) begin
              if (bit_cnt == 4'd0) state <= GAP;
              else                 bit_cnt <= bit_cnt - 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        GAP: begin
          if (half_done) begin
            div_cnt <= '0;
            phase   <= ~phase;
            if (phase) state <= IDLE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shift register holds the in-flight sample; advances after each sclk high phase.
  always_ff @(posedge clk) begin
    if (pop)
      shreg <= load_word(fifo_dout);
    else if ((state == SHIFT) && half_done && phase)
      shreg <= shreg << 1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      bus.ovf <= 1'b0;
    else if (bus.trans_in && fifo_full && !pop)
      bus.ovf <= 1'b1;
    else if (bus.ovf_clr)
      bus.ovf <= 1'b0;
  end

endmodule

// File: tb/tb_dds_dac_serializer.sv
// Directed bench for dds_dac_serializer: one instance at DIV=1 and one at DIV=3, both DEPTH=4.
module tb_dds_dac_serializer;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  dds_dac_serializer_if ifa();
  dds_dac_serializer_if ifb();

  dds_dac_serializer #(.DIV(1), .DEPTH(4)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  dds_dac_serializer #(.DIV(3), .DEPTH(4)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

`ifdef DDS_DAC_OFFSET_BIN_EN
  localparam logic [15:0] EXP_8001 = 16'h0001;
  localparam logic [15:0] EXP_7FFF = 16'hFFFF;
`else
  localparam logic [15:0] EXP_8001 = 16'h8001;
  localparam logic [15:0] EXP_7FFF = 16'h7FFF;
`endif

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ser(input logic [15:0] s);
`ifdef DDS_DAC_OFFSET_BIN_EN
    return s ^ 16'h8000;
`else
    return s;
`endif
  endfunction

  // Frame monitor for the DIV=1 instance
  logic [15:0] a_word_q[$];
  int          a_bits_q[$];
  int          a_low_q[$];
  int          a_gap_q[$];
  int          a_busy_q[$];
  int          a_blow_q[$];

  initial begin
    logic [15:0] w;
    int bits, low, hi, bsy, blow;
    logic seen, pcs, psclk, pbusy;
    w = '0; bits = 0; low = 0; hi = 0; bsy = 0; blow = 0;
    seen = 1'b0; pcs = 1'b1; psclk = 1'b0; pbusy = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        seen = 1'b0; pcs = 1'b1; psclk = 1'b0; pbusy = 1'b0;
        bsy = 0; blow = 0; hi = 0;
      end else begin
        if (!ifa.dac_cs_n) begin
          if (pcs) begin
            if (seen) a_gap_q.push_back(hi);
            w = '0; bits = 0; low = 0;
          end
          low++;
          if (ifa.dac_sclk && !psclk) begin
            w = {w[14:0], ifa.dac_sdata};
            bits++;
          end
        end else begin
          if (!pcs) begin
            a_word_q.push_back(w);
            a_bits_q.push_back(bits);
            a_low_q.push_back(low);
            seen = 1'b1;
            hi = 0;
          end
          hi++;
        end
        if (ifa.busy) begin
          if (!pbusy && seen) a_blow_q.push_back(blow);
          bsy++;
          blow = 0;
        end else begin
          if (pbusy) a_busy_q.push_back(bsy);
          bsy = 0;
          blow++;
        end
        pcs = ifa.dac_cs_n; psclk = ifa.dac_sclk; pbusy = ifa.busy;
      end
    end
  end

  // Frame monitor for the DIV=3 instance, tracking sclk half-period lengths
  logic [15:0] b_word_q[$];
  int          b_low_q[$];
  int          b_hmin, b_hmax, b_lmin, b_lmax;

  task automatic b_run(input logic lv, input int r);
    if (lv) begin
      if (r < b_hmin) b_hmin = r;
      if (r > b_hmax) b_hmax = r;
    end else begin
      if (r < b_lmin) b_lmin = r;
      if (r > b_lmax) b_lmax = r;
    end
  endtask

  initial begin
    logic [15:0] w;
    int low, r;
    logic pcs, psclk, lv;
    w = '0; low = 0; r = 0; pcs = 1'b1; psclk = 1'b0; lv = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        pcs = 1'b1; psclk = 1'b0;
      end else begin
        if (!ifb.dac_cs_n) begin
          if (pcs) begin
            w = '0; low = 0; r = 0; lv = ifb.dac_sclk;
            b_hmin = 1000; b_hmax = 0; b_lmin = 1000; b_lmax = 0;
          end
          low++;
          if (ifb.dac_sclk == lv) r++;
          else begin
            b_run(lv, r);
            lv = ifb.dac_sclk;
            r = 1;
          end
          if (ifb.dac_sclk && !psclk) w = {w[14:0], ifb.dac_sdata};
        end else if (!pcs) begin
          b_run(lv, r);
          b_word_q.push_back(w);
          b_low_q.push_back(low);
        end
        pcs = ifb.dac_cs_n; psclk = ifb.dac_sclk;
      end
    end
  end

  task automatic wait_a(input int n, input int budget);
    int k;
    k = 0;
    while (a_word_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("wait_a_frames", 32'(a_word_q.size()), 32'(n));
  endtask

  task automatic wait_b(input int n, input int budget);
    int k;
    k = 0;
    while (b_word_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("wait_b_frames", 32'(b_word_q.size()), 32'(n));
  endtask

  initial begin
    int base;
    logic [15:0] e;
    reset = 1'b0;
    ifa.sin_amp = '0; ifa.trans_in = 1'b0; ifa.ovf_clr = 1'b0;
    ifb.sin_amp = '0; ifb.trans_in = 1'b0; ifb.ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", ifa.dac_cs_n, 1);
    chk("rst_sclk", ifa.dac_sclk, 0);
    chk("rst_sdata", ifa.dac_sdata, 0);
    chk("rst_busy", ifa.busy, 0);
    chk("rst_ovf", ifa.ovf, 0);
    chk("rst_cs_n_b", ifb.dac_cs_n, 1);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single sample: latency, content, frame and gap length
    base = a_word_q.size();
    e = ser(16'hA5C3);
    ifa.sin_amp = 16'hA5C3; ifa.trans_in = 1'b1;
    @(negedge clk);
    ifa.trans_in = 1'b0;
    @(negedge clk);
    chk("lat_t1_cs_n", ifa.dac_cs_n, 1);
    @(negedge clk);
    chk("lat_t2_cs_n", ifa.dac_cs_n, 0);
    chk("lat_t2_sdata", ifa.dac_sdata, e[15]);
    chk("lat_t2_busy", ifa.busy, 1);
    wait_a(base + 1, 100);
    chk("single_word", a_word_q[base], e);
    chk("single_bits", a_bits_q[base], 16);
    chk("single_low", a_low_q[base], 32);
    repeat (4) @(negedge clk);
    chk("single_busy_len", a_busy_q[a_busy_q.size()-1], 34);

    // Back-to-back pair, also covering offset-binary extremes
    base = a_word_q.size();
    ifa.sin_amp = 16'h8001; ifa.trans_in = 1'b1;
    @(negedge clk);
    ifa.sin_amp = 16'h7FFF;
    @(negedge clk);
    ifa.trans_in = 1'b0;
    wait_a(base + 2, 200);
    chk("b2b_word0", a_word_q[base], EXP_8001);
    chk("b2b_word1", a_word_q[base+1], EXP_7FFF);
    chk("b2b_low1", a_low_q[base+1], 32);
    chk("b2b_gap", a_gap_q[a_gap_q.size()-1], 3);
    repeat (4) @(negedge clk);
    chk("b2b_busy_low", a_blow_q[a_blow_q.size()-1], 1);
    chk("b2b_busy_len0", a_busy_q[a_busy_q.size()-2], 34);
    chk("b2b_busy_len1", a_busy_q[a_busy_q.size()-1], 34);

    // Overflow: 8 samples into a 4-deep FIFO, set beats a same-cycle clear
    base = a_word_q.size();
    for (int i = 1; i <= 8; i++) begin
      ifa.sin_amp = 16'(i);
      ifa.trans_in = 1'b1;
      ifa.ovf_clr = (i == 7);
      @(negedge clk);
      if (i == 5) chk("ovf_before_drop", ifa.ovf, 0);
      if (i == 6) chk("ovf_on_drop", ifa.ovf, 1);
      if (i == 7) chk("ovf_set_beats_clr", ifa.ovf, 1);
    end
    ifa.trans_in = 1'b0; ifa.ovf_clr = 1'b0;
    wait_a(base + 5, 250);
    for (int i = 0; i < 5; i++) chk("ovf_word", a_word_q[base+i], ser(16'(i + 1)));
    repeat (40) @(negedge clk);
    chk("ovf_no_extra", 32'(a_word_q.size()), 32'(base + 5));
    chk("ovf_sticky", ifa.ovf, 1);
    ifa.ovf_clr = 1'b1;
    @(negedge clk);
    ifa.ovf_clr = 1'b0;
    chk("ovf_clr", ifa.ovf, 0);

    // Divider: DIV=3 instance
    base = b_word_q.size();
    ifb.sin_amp = 16'h3C96; ifb.trans_in = 1'b1;
    @(negedge clk);
    ifb.trans_in = 1'b0;
    wait_b(base + 1, 300);
    chk("div3_word", b_word_q[base], ser(16'h3C96));
    chk("div3_low", b_low_q[base], 96);
    chk("div3_hmin", b_hmin, 3);
    chk("div3_hmax", b_hmax, 3);
    chk("div3_lmin", b_lmin, 3);
    chk("div3_lmax", b_lmax, 3);

    // Reset in the middle of a frame with ovf set
    for (int i = 0; i < 6; i++) begin
      ifa.sin_amp = 16'h1234; ifa.trans_in = 1'b1;
      @(negedge clk);
    end
    ifa.trans_in = 1'b0;
    chk("pre_rst_ovf", ifa.ovf, 1);
    repeat (8) @(negedge clk);
    chk("pre_rst_cs_n", ifa.dac_cs_n, 0);
    reset = 1'b0;
    #1;
    chk("rst_mid_cs_n", ifa.dac_cs_n, 1);
    chk("rst_mid_sclk", ifa.dac_sclk, 0);
    chk("rst_mid_ovf", ifa.ovf, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_rel_busy", ifa.busy, 0);
    repeat (10) @(negedge clk);
    chk("rst_no_resume_cs_n", ifa.dac_cs_n, 1);
    chk("rst_no_resume_busy", ifa.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dds_dac_serializer.md
# dds_dac_serializer

Output stage of the DDS chain, directly downstream of the sine-amplitude generator. Captures each 16-bit `sin_amp` sample qualified by the generator's `trans_pac` strobe into a small FIFO. Drains the FIFO as MSB-first serial frames to an external SPI-style DAC (`sclk`, `sdata`, `cs_n`). Flags samples lost to FIFO overflow with a sticky bit.

## Interface
Parameters:
- `DIV`, default 2: clk cycles per sclk half-period; legal range ≥1.
- `DEPTH`, default 4: FIFO depth in samples; power of two, ≥2.

Ports:
- `clk`, input, 1: system clock; all logic is on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `sin_amp`, input, 16: sample from the upstream generator, two's complement.
- `trans_in`, input, 1: sample-valid strobe, driven by the upstream `trans_pac`; one sample per high cycle.
- `ovf_clr`, input, 1: synchronous clear of `ovf`.
- `dac_sclk`, output, 1: DAC serial clock.
- `dac_sdata`, output, 1: DAC serial data.
- `dac_cs_n`, output, 1: DAC chip select, active low.
- `busy`, output, 1: high whenever a frame is in progress (states SHIFT or GAP).
- `ovf`, output, 1: sticky flag; set when a sample is dropped.

## Operation
- **Push:** when `trans_in`=1 and the FIFO is not full, `sin_amp` is written. When full, the sample is dropped and `ovf` is set.
- **Simultaneous push and pop on a full FIFO:** the push is accepted and `ovf` stays unchanged.
- **`ovf` priority:** a set in the same cycle as `ovf_clr` wins. `ovf` is cleared otherwise only by reset.
- **FSM states:** IDLE, SHIFT, GAP.
- **IDLE:**
  - If the FIFO is non-empty: pop into a 16-bit shift register and go to SHIFT.
  - Otherwise stay in IDLE with `dac_cs_n`=1 and `dac_sclk`=0.
- **SHIFT:**
  - `dac_cs_n`=0.
  - Each bit period is 2·DIV cycles: `dac_sclk`=0 for DIV cycles, then 1 for DIV cycles.
  - `dac_sdata` changes only at the start of a bit period. The DAC samples on the sclk rising edge.
  - After the high phase of bit 0, go to GAP.
- **GAP:**
  - `dac_cs_n`=1, `dac_sclk`=0, for 2·DIV cycles, then go to IDLE.
- **Counters:**
  - Bit counter: 4 bits, counts 15 down to 0.
  - Divider counter: width clog2(DIV)+1; wraps at DIV−1.
- **FIFO pointers:** clog2(DEPTH)+1 bits. The extra MSB distinguishes full from empty.
- **Sample width:** no arithmetic on the sample. Bit order on `dac_sdata` is bit 15 first.

## Timing
- **Reset values:** `dac_sclk`=0, `dac_sdata`=0, `dac_cs_n`=1, `busy`=0, `ovf`=0; FIFO empty; FSM in IDLE. All outputs are registered.
- **Reset mid-frame:** the frame is aborted and `dac_cs_n` goes high immediately (asynchronous). No partial resume after reset release.
- **Latency, empty FIFO:**
  - Sample with `trans_in` high at edge t is written at t.
  - The FSM pops at t+1.
  - `dac_cs_n`=0 and `dac_sdata`=bit 15 are visible after edge t+2.
- **Frame length:** 32·DIV cycles of `cs_n` low plus 2·DIV cycles of gap. Add 1 IDLE cycle per frame for the pop.
- **Steady-state capacity:** one sample every 34·DIV+1 cycles. Faster input fills the FIFO and then sets `ovf`.
- **Back-to-back frames:** a non-empty FIFO at GAP exit causes a pop in the single IDLE cycle. `cs_n` is high for 2·DIV+1 cycles between frames.

## Configuration
- Macro: `DDS_DAC_OFFSET_BIN_EN`.
- **Defined:** the sample is converted to offset binary by inverting bit 15 when loaded into the shift register (e.g. 0x8001 → 0x0001; 0x7FFF → 0xFFFF).
- **Undefined:** the two's-complement sample is shifted out unchanged.

## Structure
- **Shared package `dds_pkg`:**
  - `SAMPLE_W`=16.
  - FSM state enum `dac_state_t` (IDLE, SHIFT, GAP).
  - `clog2` helper function.
- **Sub-module `dds_sample_fifo`:**
  - Synchronous FIFO, parameters `WIDTH` and `DEPTH`.
  - Ports: push, pop, din, dout, full, empty. Asynchronous active-low reset.
  - The serializer FSM, divider and shift register live in the top module.

## Test plan
- **Reset check:** reset low mid-frame, DIV=1 → `dac_cs_n`=1, `dac_sclk`=0, `ovf`=0 within the same cycle; `busy`=0 after release.
- **Single sample:** DIV=1, one sample 0xA5C3 without the macro → `cs_n` low after edge t+2. Sdata on 16 rising sclk edges = 1010 0101 1100 0011. Then `cs_n` is high for 2 cycles.
- **Offset binary:** with `DDS_DAC_OFFSET_BIN_EN` defined, sample 0x8001 → serial 0x0001. Sample 0x7FFF → serial 0xFFFF.
- **Divider:** DIV=3 → each sclk half-period is 3 cycles; the frame has `cs_n` low for 96 cycles.
- **Overflow:** DEPTH=4, DIV=1, `trans_in` high for 8 consecutive cycles with values 1..8 → frames carry 1 then 2, 3, 4, 5. Samples 6..8 are dropped and `ovf`=1. `ovf_clr` for one cycle → `ovf`=0.
- **Back-to-back:** two samples pushed on consecutive cycles → two frames separated by `cs_n` high for exactly 3 cycles at DIV=1; `busy` drops only during the IDLE cycle.
